spi_ram_burst: RTL and testbench
================================

# spi_ram_burst

Parametrised single-port synchronous RAM that sits behind the SPI slave and decodes its received command words. It generalises the fixed 8-bit/256-entry command RAM to configurable data width, address width and depth. It adds per-command auto-increment burst addressing, wrap-around at a non-power-of-two depth, and an address-range error flag. Host traffic arrives as `rx_valid`-qualified command words; read data returns to the SPI slave as `dout` with a `tx_valid` pulse.

## Interface
- `DATA_W`, default 8: data word width; payload width of every command.
- `ADDR_W`, default 8: address pointer width. Must satisfy `ADDR_W <= DATA_W`.
- `MEM_DEPTH`, default 256: number of words. Must satisfy `1 <= MEM_DEPTH <= 2**ADDR_W`; need not be a power of two.
- `clk` input 1: clock, all logic on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `rx_valid` input 1: `din` holds a valid command this cycle.
- `din` input `DATA_W+2`: command word. `din[DATA_W+1:DATA_W]` is the opcode; `din[DATA_W-1:0]` is the payload.
- `auto_inc` input 1: burst mode for the current command; sampled only when `rx_valid` is 1.
- `dout` output `DATA_W`: read data; holds its value between reads.
- `tx_valid` output 1: one-cycle pulse marking new `dout`.
- `addr_err` output 1: one-cycle pulse on a rejected address load.

## Operation
- **Internal state:** `mem[MEM_DEPTH]`, `wr_addr[ADDR_W]`, `rd_addr[ADDR_W]`. Memory contents are not reset.
- **Reset** (`rst_n`=0 at a clock edge): `dout`=0, `tx_valid`=0, `addr_err`=0, `wr_addr`=0, `rd_addr`=0. Reset overrides any command in the same cycle.
- **Idle** (`rx_valid`=0): `tx_valid`=0, `addr_err`=0; pointers, memory and `dout` are unchanged.
- **Opcode 00, write-address load:** `A = din[ADDR_W-1:0]`.
  - If `din[DATA_W-1:ADDR_W]` ≠ 0 or `A >= MEM_DEPTH`: `wr_addr` is unchanged and `addr_err` pulses.
  - Otherwise `wr_addr <= A`.
  - `auto_inc` is ignored.
- **Opcode 01, write data:** `mem[wr_addr] <= din[DATA_W-1:0]`.
  - If `auto_inc`=1, `wr_addr` then advances by 1.
  - The pointer wraps from `MEM_DEPTH-1` to 0.
- **Opcode 10, read-address load:** same range check as opcode 00, applied to `rd_addr`.
- **Opcode 11, read data:** `dout <= mem[rd_addr]` and `tx_valid` pulses.
  - `din` payload is ignored.
  - If `auto_inc`=1, `rd_addr` advances with the same wrap rule as writes.
- **Output pulses:** `tx_valid` is 0 on every cycle that is not an accepted opcode-11 command. `addr_err` is 0 on every cycle without a rejected address load. Both flags are never high together.
- **Pointer range:** pointers can never hold a value `>= MEM_DEPTH`, so data commands never raise errors.
- **Arithmetic:** pointer increment is `ADDR_W` bits with an explicit compare against `MEM_DEPTH-1`. It never relies on natural overflow unless `MEM_DEPTH == 2**ADDR_W`, where both give the same result.

## Timing
- All outputs are registered.
- Opcode 11 accepted at edge N gives `dout` and `tx_valid`=1 visible after edge N, for one cycle; `tx_valid` drops at edge N+1 unless another read is accepted there.
- Back-to-back reads on consecutive cycles keep `tx_valid` high continuously, with `dout` updating every cycle.
- Write at edge N followed by a read of the same address at edge N+1 returns the newly written data (read-after-write, no bypass hazard).
- Opcode 00/10 at edge N: the new pointer is used by a data command at edge N+1.
- `addr_err` goes high after the rejecting edge for exactly one cycle.
- Reset mid-burst: pointers return to 0. The burst does not resume; the host must reload the addresses.
- No back-pressure: one command is accepted every cycle that `rx_valid`=1.

## Test plan
Defaults `DATA_W`=8, `ADDR_W`=8, with `MEM_DEPTH`=200 unless noted.

- **Reset:** drive `rst_n`=0 for 2 cycles while issuing opcode 11 → `dout`=0x00, `tx_valid`=0, `addr_err`=0; the first read after reset uses `rd_addr`=0.
- **Single write/read:** load `wr_addr`=0x10, write 0xA5, load `rd_addr`=0x10, read → `dout`=0xA5 one cycle after the read, with `tx_valid` high for exactly 1 cycle.
- **Burst with wrap:** load `wr_addr`=198, then write 0x11, 0x22, 0x33 with `auto_inc`=1 → mem[198]=0x11, mem[199]=0x22, mem[0]=0x33. Then read 3 words from 198 with `auto_inc`=1 → `dout` 0x11, 0x22, 0x33 on consecutive cycles with `tx_valid` held high.
- **Address rejection:** opcode 00 with payload 200 → `addr_err` pulses 1 cycle and `wr_addr` keeps its prior value. A following write lands at the old address; payload 199 is accepted with no error.
- **Read-after-write and idle gaps:** write 0x5A to address 5, then read address 5 in the next cycle → 0x5A. Then hold `rx_valid`=0 for 4 cycles → `tx_valid`=0 and `dout` holds 0x5A.
- **Parameter sweep:** repeat the burst test with `DATA_W`=16, `ADDR_W`=10, `MEM_DEPTH`=1024 → wrap from 1023 to 0 works, and 16-bit data such as 0xBEEF reads back intact.

Source files
------------

// File: rtl/spi_ram_burst.sv
// Command-decoding single-port RAM behind the SPI slave: address loads, data
// writes/reads with optional auto-increment bursts that wrap at MEM_DEPTH.
module spi_ram_burst #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [DATA_W+1:0] din,
   input  logic              auto_inc,
   output logic [DATA_W-1:0] dout,
   output logic              tx_valid,
   output logic              addr_err
);

   typedef enum logic [1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_RD_DATA = 2'b11
   } op_e;

   // One extra bit so MEM_DEPTH == 2**ADDR_W is representable in the compare.
   localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MEM_DEPTH - 1);

   logic [DATA_W-1:0] mem [MEM_DEPTH];
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [ADDR_W-1:0] wr_addr_nxt, rd_addr_nxt;
   logic [ADDR_W-1:0] wr_inc, rd_inc;
   logic [DATA_W-1:0] payload;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_bad;
   logic              tx_nxt, err_nxt;
   op_e               op;

   assign op      = op_e'(din[DATA_W+1:DATA_W]);
   assign payload = din[DATA_W-1:0];
   assign ld_addr = payload[ADDR_W-1:0];
   // Shift rather than slice so ADDR_W == DATA_W needs no special case.
   assign ld_bad  = ((payload >> ADDR_W) != '0) || ({1'b0, ld_addr} >= DEPTH);

   assign wr_inc = (wr_addr == LAST) ? '0 : wr_addr + ADDR_W'(1);
   assign rd_inc = (rd_addr == LAST) ? '0 : rd_addr + ADDR_W'(1);

   always_comb begin
      wr_addr_nxt = wr_addr;
      rd_addr_nxt = rd_addr;
      tx_nxt      = 1'b0;
      err_nxt     = 1'b0;
      if (rx_valid) begin
         unique case (op)
            OP_WR_ADDR: begin
               if (ld_bad) err_nxt = 1'b1;
               else        wr_addr_nxt = ld_addr;
            end
            OP_WR_DATA: begin
               if (auto_inc) wr_addr_nxt = wr_inc;
            end
            OP_RD_ADDR: begin
               if (ld_bad) err_nxt = 1'b1;
               else        rd_addr_nxt = ld_addr;
            end
            OP_RD_DATA: begin
               tx_nxt = 1'b1;
               if (auto_inc) rd_addr_nxt = rd_inc;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_addr  <= '0;
         rd_addr  <= '0;
         tx_valid <= 1'b0;
         addr_err <= 1'b0;
         dout     <= '0;
      end else begin
         wr_addr  <= wr_addr_nxt;
         rd_addr  <= rd_addr_nxt;
         tx_valid <= tx_nxt;
         addr_err <= err_nxt;
         if (tx_nxt) dout <= mem[rd_addr];
      end
   end

   // Storage carries no reset; gated by rst_n so a reset cycle cannot write.
   always_ff @(posedge clk) begin
      if (rst_n && rx_valid && op == OP_WR_DATA)
         mem[wr_addr] <= payload;
   end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench: 8-bit/200-deep instance for functional cases, 16-bit/1024-deep
// instance for the wider-parameter burst and wrap.
module tb_spi_ram_burst;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid, auto_inc;
   logic [9:0]  din;
   logic [7:0]  dout;
   logic        tx_valid, addr_err;

   logic        rx_valid16, auto_inc16;
   logic [17:0] din16;
   logic [15:0] dout16;
   logic        tx_valid16, addr_err16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200)) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din),
      .auto_inc(auto_inc), .dout(dout), .tx_valid(tx_valid), .addr_err(addr_err)
   );

   spi_ram_burst #(.DATA_W(16), .ADDR_W(10), .MEM_DEPTH(1024)) dut16 (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid16), .din(din16),
      .auto_inc(auto_inc16), .dout(dout16), .tx_valid(tx_valid16), .addr_err(addr_err16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] pl, input logic ai);
      @(negedge clk);
      rx_valid = 1'b1; din = {op, pl}; auto_inc = ai;
      @(posedge clk); #1;
   endtask

   task automatic send16(input logic [1:0] op, input logic [15:0] pl, input logic ai);
      @(negedge clk);
      rx_valid16 = 1'b1; din16 = {op, pl}; auto_inc16 = ai;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      @(negedge clk);
      rx_valid = 1'b0; rx_valid16 = 1'b0; auto_inc = 1'b0; auto_inc16 = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; rx_valid = 1'b0; auto_inc = 1'b0; din = '0;
      rx_valid16 = 1'b0; auto_inc16 = 1'b0; din16 = '0;

      // Reset held 2 cycles while a read is issued
      send(2'b11, 8'h00, 1'b0);
      send(2'b11, 8'h00, 1'b0);
      chk("rst_dout", dout, 8'h00);
      chk("rst_tx", tx_valid, 1'b0);
      chk("rst_err", addr_err, 1'b0);
      chk("rst_dout16", dout16, 16'h0000);
      @(negedge clk); rst_n = 1'b1;

      // Pointers start at 0
      send(2'b01, 8'h3C, 1'b0);
      send(2'b11, 8'h00, 1'b0);
      chk("first_rd_dout", dout, 8'h3C);
      chk("first_rd_tx", tx_valid, 1'b1);

      // Single write/read
      send(2'b00, 8'h10, 1'b0);
      send(2'b01, 8'hA5, 1'b0);
      send(2'b10, 8'h10, 1'b0);
      chk("single_pre_tx", tx_valid, 1'b0);
      send(2'b11, 8'hFF, 1'b0);
      chk("single_dout", dout, 8'hA5);
      chk("single_tx", tx_valid, 1'b1);
      idle();
      chk("single_tx_drop", tx_valid, 1'b0);
      chk("single_hold", dout, 8'hA5);

      // Burst write/read across the 199 -> 0 wrap
      send(2'b00, 8'd198, 1'b0);
      send(2'b01, 8'h11, 1'b1);
      send(2'b01, 8'h22, 1'b1);
      send(2'b01, 8'h33, 1'b1);
      send(2'b10, 8'd198, 1'b0);
      send(2'b11, 8'h00, 1'b1);
      chk("burst_rd0", dout, 8'h11);
      chk("burst_tx0", tx_valid, 1'b1);
      send(2'b11, 8'h00, 1'b1);
      chk("burst_rd1", dout, 8'h22);
      chk("burst_tx1", tx_valid, 1'b1);
      send(2'b11, 8'h00, 1'b1);
      chk("burst_rd2", dout, 8'h33);
      chk("burst_tx2", tx_valid, 1'b1);
      chk("burst_err", addr_err, 1'b0);

      // Write pointer now at 1; out-of-range loads are rejected
      send(2'b00, 8'd200, 1'b0);
      chk("rej_err", addr_err, 1'b1);
      chk("rej_tx", tx_valid, 1'b0);
      idle();
      chk("rej_err_drop", addr_err, 1'b0);
      send(2'b01, 8'h77, 1'b0);
      send(2'b10, 8'd1, 1'b0);
      send(2'b11, 8'h00, 1'b0);
      chk("rej_old_addr", dout, 8'h77);
      send(2'b00, 8'd199, 1'b0);
      chk("acc199_err", addr_err, 1'b0);
      send(2'b01, 8'h99, 1'b0);
      send(2'b10, 8'd199, 1'b0);
      send(2'b11, 8'h00, 1'b0);
      chk("acc199_dout", dout, 8'h99);
      send(2'b10, 8'd255, 1'b0);
      chk("rd_rej_err", addr_err, 1'b1);
      send(2'b11, 8'h00, 1'b0);
      chk("rd_rej_keep", dout, 8'h99);
      chk("rd_rej_err_drop", addr_err, 1'b0);

      // Read-after-write in consecutive cycles, then idle gap
      send(2'b10, 8'd5, 1'b0);
      send(2'b00, 8'd5, 1'b0);
      send(2'b01, 8'h5A, 1'b0);
      send(2'b11, 8'h00, 1'b0);
      chk("raw_dout", dout, 8'h5A);
      chk("raw_tx", tx_valid, 1'b1);
      for (int i = 0; i < 4; i++) begin
         idle();
         chk("idle_tx", tx_valid, 1'b0);
         chk("idle_dout", dout, 8'h5A);
      end

      // Wide instance: 16-bit data, wrap 1023 -> 0
      send16(2'b00, 16'h0400, 1'b0);
      chk("w16_rej_err", addr_err16, 1'b1);
      send16(2'b00, 16'h03FF, 1'b0);
      chk("w16_acc_err", addr_err16, 1'b0);
      send16(2'b01, 16'hBEEF, 1'b1);
      send16(2'b01, 16'h1234, 1'b1);
      send16(2'b01, 16'hCAFE, 1'b1);
      send16(2'b10, 16'h03FF, 1'b0);
      send16(2'b11, 16'h0000, 1'b1);
      chk("w16_rd0", dout16, 16'hBEEF);
      chk("w16_tx0", tx_valid16, 1'b1);
      send16(2'b11, 16'h0000, 1'b1);
      chk("w16_rd1", dout16, 16'h1234);
      send16(2'b11, 16'h0000, 1'b1);
      chk("w16_rd2", dout16, 16'hCAFE);
      chk("w16_tx2", tx_valid16, 1'b1);
      idle();
      chk("w16_tx_drop", tx_valid16, 1'b0);

      // Reset mid-burst returns pointers to 0
      send(2'b00, 8'd0, 1'b0);
      send(2'b01, 8'hE1, 1'b1);
      send(2'b01, 8'hE2, 1'b1);
      @(negedge clk); rst_n = 1'b0; rx_valid = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_tx", tx_valid, 1'b0);
      chk("mid_rst_dout", dout, 8'h00);
      @(negedge clk); rst_n = 1'b1;
      send(2'b11, 8'h00, 1'b1);
      chk("mid_rst_rd0", dout, 8'hE1);
      send(2'b11, 8'h00, 1'b0);
      chk("mid_rst_rd1", dout, 8'hE2);

      idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
